seq_multiplier: RTL

//  Unsigned 8x8 -> 16-bit shift-and-add multiplier. Computes one partial product per

---
 rtl/seq_multiplier_pkg.sv | 14 +
 rtl/seq_multiplier_if.sv | 17 +
 rtl/seq_multiplier_adder.sv | 23 ++
 rtl/seq_multiplier.sv | 97 +++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared types and constants for the sequential multiplier.
//   state_t   : FSM state codes (IDLE=0, RUN=1, DONE=2)
//   MUL_W     : operand width the adder is built for
//   MUL_ITER  : shift-and-add iterations per product
package seq_multiplier_pkg;
  localparam int MUL_W    = 8;
  localparam int MUL_ITER = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: request/result bundle of the multiplier.
//   i_start/i_a/i_b : request and operands (driven by master)
//   o_ready/o_busy/o_done/o_product : status and result (driven by slave)
interface seq_multiplier_if #(parameter int W = 8);
  logic           i_start;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic           o_ready;
  logic           o_busy;
  logic           o_done;
  logic [2*W-1:0] o_product;

  modport master (output i_start, i_a, i_b,
                  input  o_ready, o_busy, o_done, o_product);
  modport slave  (input  i_start, i_a, i_b,
                  output o_ready, o_busy, o_done, o_product);
endinterface

// File: rtl/seq_multiplier_adder.sv
// seq_multiplier_adder: 8-bit ripple-carry adder, carry-out not exported.
//   i_a, i_b : addends
//   i_c      : carry-in
//   o_c      : 8-bit sum (carry out of bit 7 is dropped)
module seq_multiplier_adder
  import seq_multiplier_pkg::*;
(
  input  logic [MUL_W-1:0] i_a,
  input  logic [MUL_W-1:0] i_b,
  input  logic             i_c,
  output logic [MUL_W-1:0] o_c
);
  logic [MUL_W-1:0] carry;

  assign carry[0] = i_c;

  for (genvar i = 0; i < MUL_W; i++) begin : g_fa
    assign o_c[i] = i_a[i] ^ i_b[i] ^ carry[i];
    if (i < MUL_W - 1) begin : g_cy
      assign carry[i+1] = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & carry[i]);
    end
  end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned 8x8 -> 16 shift-and-add multiplier, one partial
// product per clock using the ripple adder. Accept at edge 0, o_done in cycle 9.
//   i_clk   : clock, all state on rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of seq_multiplier_if (start/operands in, status/product out)
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  seq_multiplier_if.slave bus
);
  if (WIDTH != MUL_W) begin : g_width_chk
    $error("seq_multiplier: WIDTH must be 8 to match the adder");
  end

  state_t           state;
  logic [MUL_W-1:0] m, acc, q;
  logic [2:0]       cnt;
  logic             ready_q, busy_q, done_q;
  logic [2*MUL_W-1:0] product_q;

  logic [MUL_W-1:0]   sum;
  logic               carry;
  logic [2*MUL_W-1:0] shifted;

  seq_multiplier_adder u_adder (
    .i_a (acc),
    .i_b (m),
    .i_c (1'b0),
    .o_c (sum)
  );

  // The adder drops carry7; rebuild it from the MSBs: a carry out exists if
  // both MSBs are set, or exactly one is set and the sum MSB wrapped to 0.
  assign carry   = (acc[MUL_W-1] & m[MUL_W-1]) |
                   ((acc[MUL_W-1] ^ m[MUL_W-1]) & ~sum[MUL_W-1]);
  assign shifted = q[0] ? {carry, sum, q[MUL_W-1:1]}
                        : {1'b0, acc, q[MUL_W-1:1]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      cnt       <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            m       <= bus.i_a;
            acc     <= '0;
            q       <= bus.i_b;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          {acc, q} <= shifted;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'(MUL_ITER - 1)) begin
            // Final iteration: the result lands directly in the output register.
            product_q <= shifted;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_product = product_q;
endmodule
